// File: rtl/data_ram_pkg.sv
// Shared encodings for the byte-enabled data RAM: access sizes, FSM states
// and the alignment rule used by the request decoder.
package data_ram_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_RSV = 2'd3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Reserved size is never legal; halves need an even address, words a 4-byte boundary.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~lane[0];
            SZ_W:    ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ram_lane_extract.sv
// Selects the addressed byte/half of a 32-bit word and sign- or zero-extends it.
module ram_lane_extract
    import data_ram_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension; reserved size yields zero.
    always_comb begin
        byte_s = word_i[{addr_i, 3'b000} +: 8];
        half_s = addr_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_B: begin
                if (uns_i) begin
                    ext_o = {24'h000000, byte_s};
                end else begin
                    ext_o = {{24{byte_s[7]}}, byte_s};
                end
            end
            SZ_H: begin
                if (uns_i) begin
                    ext_o = {16'h0000, half_s};
                end else begin
                    ext_o = {{16{half_s[15]}}, half_s};
                end
            end
            SZ_W:    ext_o = word_i;
            default: ext_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_ram_be.sv
// Byte-addressed data RAM for the MEM stage: lane-enabled stores, extended
// registered loads, misalignment strobe and a post-reset zero-fill sweep.
module data_ram_be
    import data_ram_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              sel,
    input  logic              ld,
    input  logic              str,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              misalign,
    output logic              busy
);

    localparam int               WORD_W    = ADDR_W - 2;
    localparam int               DEPTH     = 1 << WORD_W;
    localparam logic [WORD_W-1:0] LAST_PTR = '1;
    localparam state_e           RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

    logic [31:0]       mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [WORD_W-1:0] ptr_q, ptr_d;
    logic              clear_we_s;
    logic              busy_s;

    logic [WORD_W-1:0] word_idx_s;
    logic [1:0]        lane_s;
    logic              aligned_s;
    logic              req_s, load_s, store_s, mis_s;
    logic [3:0]        be_raw_s, be_s;
    logic [31:0]       wlanes_s;
    logic [31:0]       rd_word_s, ext_s;

    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              misalign_q, misalign_d;

    // Sweep FSM next-state: clear one word per cycle, leave after the last one.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clear_we_s = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_we_s = 1'b1;
                ptr_d      = ptr_q + WORD_W'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = RST_STATE;
        endcase
    end

    // Sweep FSM state and pointer registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy_s = (state_q == ST_CLEAR);

    // Request decode: busy masks everything, misaligned requests never touch memory.
    always_comb begin
        word_idx_s = address[ADDR_W-1:2];
        lane_s     = address[1:0];
        aligned_s  = is_aligned(size, lane_s);
        req_s      = sel & (ld | str) & ~busy_s;
        load_s     = req_s & ld & aligned_s;
        store_s    = req_s & str & aligned_s;
        mis_s      = req_s & ~aligned_s;
    end

    // Lane enables and lane-replicated store data.
    always_comb begin
        case (size)
            SZ_B: begin
                be_raw_s = 4'b0001 << lane_s;
                wlanes_s = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be_raw_s = lane_s[1] ? 4'b1100 : 4'b0011;
                wlanes_s = {2{wdata[15:0]}};
            end
            SZ_W: begin
                be_raw_s = 4'b1111;
                wlanes_s = wdata;
            end
            default: begin
                be_raw_s = 4'b0000;
                wlanes_s = wdata;
            end
        endcase
        if (store_s) begin
            be_s = be_raw_s;
        end else begin
            be_s = 4'b0000;
        end
    end

    // Array write port, shared between the clear sweep and byte-lane stores.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_q[ptr_q] <= 32'h0000_0000;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[word_idx_s][8*b +: 8] <= wlanes_s[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous array read gives read-before-write when a load and store coincide.
    assign rd_word_s = mem_q[word_idx_s];

    ram_lane_extract u_extract (
        .word_i (rd_word_s),
        .addr_i (lane_s),
        .size_i (size),
        .uns_i  (uns),
        .ext_o  (ext_s)
    );

    // Output next-state: rdata stays zero on every cycle that is not a good load.
    always_comb begin
        rvalid_d   = load_s;
        misalign_d = mis_s;
        if (load_s) begin
            rdata_d = ext_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rdata_q    <= 32'h0000_0000;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign misalign = misalign_q;
    assign busy     = busy_s;

endmodule

// File: tb/tb_data_ram_be.sv
// Scoreboard bench for data_ram_be: directed requests push expected responses,
// a negedge monitor pops and compares whenever rvalid or misalign strobes.
module tb_data_ram_be;

    logic        clk;
    logic        clr_n;
    logic        sel, ld, str, uns;
    logic [1:0]  size;
    logic [11:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid, misalign, busy;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic        is_mis;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    localparam int K_NONE = 0;
    localparam int K_RD   = 1;
    localparam int K_MIS  = 2;

    data_ram_be #(.ADDR_W(12), .INIT_CLEAR(1)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .sel      (sel),
        .ld       (ld),
        .str      (str),
        .size     (size),
        .uns      (uns),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .misalign (misalign),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (rvalid || misalign) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_response: got rvalid=%0b misalign=%0b rdata=0x%08h expected none",
                             rvalid, misalign, rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_rvalid"},   {31'd0, rvalid},   {31'd0, ~e.is_mis});
                    check({e.name, "_misalign"}, {31'd0, misalign}, {31'd0, e.is_mis});
                    check({e.name, "_rdata"},    rdata,             e.data);
                end
            end else begin
                check("idle_rdata_zero", rdata, 32'h0000_0000);
            end
        end
    end

    task automatic req(input string name, input logic l, input logic s, input logic [1:0] sz,
                       input logic u, input logic [11:0] a, input logic [31:0] wd,
                       input int kind, input logic [31:0] exp_data);
        exp_t e;
        @(posedge clk);
        #1;
        sel = 1'b1; ld = l; str = s; size = sz; uns = u; address = a; wdata = wd;
        if (kind != K_NONE) begin
            e.is_mis = (kind == K_MIS);
            e.data   = exp_data;
            e.name   = name;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        sel = 1'b0; ld = 1'b0; str = 1'b0; size = 2'd0; uns = 1'b0;
        address = 12'h000; wdata = 32'h0000_0000;
    endtask

    task automatic count_sweep(input string name);
        int cnt;
        cnt = 0;
        while (busy && cnt < 5000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check(name, cnt, 32'd1024);
    endtask

    initial begin
        clr_n = 1'b0;
        sel = 1'b0; ld = 1'b0; str = 1'b0; size = 2'd0; uns = 1'b0;
        address = 12'h000; wdata = 32'h0000_0000;

        @(posedge clk);
        #1;
        check("reset_rdata",    rdata,              32'h0000_0000);
        check("reset_rvalid",   {31'd0, rvalid},    32'd0);
        check("reset_misalign", {31'd0, misalign},  32'd0);
        check("reset_busy",     {31'd0, busy},      32'd1);
        clr_n  = 1'b1;
        mon_en = 1'b1;

        // Requests during the sweep must be ignored; the monitor flags any response.
        sel = 1'b1; ld = 1'b1; size = 2'd2; address = 12'h000;
        @(posedge clk);
        #1;
        sel = 1'b0; ld = 1'b0;
        while (busy) begin
            @(posedge clk);
            #1;
        end
        // First sweep measured from release: one cycle already elapsed above.
        mon_en = 1'b0;
        clr_n  = 1'b0;
        #2;
        clr_n  = 1'b1;
        mon_en = 1'b1;
        count_sweep("sweep_len");

        req("ld_w_000", 1'b1, 1'b0, 2'd2, 1'b0, 12'h000, 32'h0, K_RD, 32'h0000_0000);
        req("ld_w_ffc", 1'b1, 1'b0, 2'd2, 1'b0, 12'hFFC, 32'h0, K_RD, 32'h0000_0000);

        req("st_b_102", 1'b0, 1'b1, 2'd0, 1'b0, 12'h102, 32'h0000_0080, K_NONE, 32'h0);
        req("ld_w_100", 1'b1, 1'b0, 2'd2, 1'b0, 12'h100, 32'h0, K_RD, 32'h0080_0000);
        req("ld_b_102s", 1'b1, 1'b0, 2'd0, 1'b0, 12'h102, 32'h0, K_RD, 32'hFFFF_FF80);
        req("ld_b_102u", 1'b1, 1'b0, 2'd0, 1'b1, 12'h102, 32'h0, K_RD, 32'h0000_0080);

        req("st_w_200", 1'b0, 1'b1, 2'd2, 1'b0, 12'h200, 32'h1234_5678, K_NONE, 32'h0);
        req("st_h_202", 1'b0, 1'b1, 2'd1, 1'b0, 12'h202, 32'h0000_BEEF, K_NONE, 32'h0);
        req("ld_w_200", 1'b1, 1'b0, 2'd2, 1'b0, 12'h200, 32'h0, K_RD, 32'hBEEF_5678);
        req("ld_h_200s", 1'b1, 1'b0, 2'd1, 1'b0, 12'h200, 32'h0, K_RD, 32'h0000_5678);
        req("ld_h_202s", 1'b1, 1'b0, 2'd1, 1'b0, 12'h202, 32'h0, K_RD, 32'hFFFF_BEEF);
        req("ld_h_202u", 1'b1, 1'b0, 2'd1, 1'b1, 12'h202, 32'h0, K_RD, 32'h0000_BEEF);

        req("mis_st_w_201", 1'b0, 1'b1, 2'd2, 1'b0, 12'h201, 32'hDEAD_BEEF, K_MIS, 32'h0);
        req("ld_w_200_keep", 1'b1, 1'b0, 2'd2, 1'b0, 12'h200, 32'h0, K_RD, 32'hBEEF_5678);
        req("mis_ld_h_203", 1'b1, 1'b0, 2'd1, 1'b0, 12'h203, 32'h0, K_MIS, 32'h0);
        req("mis_rsv_200", 1'b1, 1'b0, 2'd3, 1'b0, 12'h200, 32'h0, K_MIS, 32'h0);
        idle();
        // sel=0 with ld/str asserted must do nothing.
        @(posedge clk);
        #1;
        ld = 1'b1; str = 1'b1; size = 2'd2; address = 12'h200; wdata = 32'hFFFF_FFFF;
        req("ld_w_200_nosel", 1'b1, 1'b0, 2'd2, 1'b0, 12'h200, 32'h0, K_RD, 32'hBEEF_5678);

        req("st_w_300", 1'b0, 1'b1, 2'd2, 1'b0, 12'h300, 32'h1111_1111, K_NONE, 32'h0);
        req("ldst_w_300", 1'b1, 1'b1, 2'd2, 1'b0, 12'h300, 32'hAAAA_AAAA, K_RD, 32'h1111_1111);
        req("ld_w_300", 1'b1, 1'b0, 2'd2, 1'b0, 12'h300, 32'h0, K_RD, 32'hAAAA_AAAA);
        req("st_b_301", 1'b0, 1'b1, 2'd0, 1'b0, 12'h301, 32'h0000_005A, K_NONE, 32'h0);
        req("ld_w_300_b2b", 1'b1, 1'b0, 2'd2, 1'b0, 12'h300, 32'h0, K_RD, 32'hAAAA_5AAA);
        idle();

        // Async reset while rvalid is high; no scoreboard entry because it is killed early.
        req("ld_w_300_kill", 1'b1, 1'b0, 2'd2, 1'b0, 12'h300, 32'h0, K_NONE, 32'h0);
        idle();
        check("pre_kill_rvalid", {31'd0, rvalid}, 32'd1);
        check("pre_kill_rdata",  rdata,           32'hAAAA_5AAA);
        #1;
        clr_n = 1'b0;
        #1;
        check("async_rvalid",   {31'd0, rvalid},   32'd0);
        check("async_rdata",    rdata,             32'h0000_0000);
        check("async_misalign", {31'd0, misalign}, 32'd0);
        check("async_busy",     {31'd0, busy},     32'd1);
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        // Reset at sweep cycle 500 restarts the full 1024-cycle sweep.
        repeat (500) begin
            @(posedge clk);
            #1;
        end
        check("mid_sweep_busy", {31'd0, busy}, 32'd1);
        clr_n = 1'b0;
        #2;
        check("mid_reset_busy", {31'd0, busy}, 32'd1);
        clr_n = 1'b1;
        count_sweep("sweep_restart_len");
        req("ld_w_300_cleared", 1'b1, 1'b0, 2'd2, 1'b0, 12'h300, 32'h0, K_RD, 32'h0000_0000);
        req("ld_w_100_cleared", 1'b1, 1'b0, 2'd2, 1'b0, 12'h100, 32'h0, K_RD, 32'h0000_0000);
        idle();

        repeat (10) begin
            if (exp_q.size() != 0) begin
                @(posedge clk);
                #1;
            end
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_ram_be.md
Name: data_ram_be

Overview:
- Byte-addressed, parametrised data memory for the pipeline CPU's MEM stage.
- Successor to the word-only RAM: adds byte/halfword/word stores via lane enables, sign/zero-extended loads, and a registered read with a valid strobe.
- Adds misalignment flagging and a post-reset hardware clear sweep that replaces simulation-only initialisation.

Parameters:
- ADDR_W, 12: byte-address width. DEPTH = 2^(ADDR_W-2) words (default 1024).
- INIT_CLEAR, 1: 1 runs the zero-fill sweep after reset; 0 leaves contents undefined and is ready immediately.

Ports:
- clk  in  1  clock, rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- sel  in  1  access request qualifier.
- ld  in  1  load request (valid with sel).
- str  in  1  store request (valid with sel).
- size  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved.
- uns  in  1  1 = zero-extend load, 0 = sign-extend.
- address  in  ADDR_W  byte address.
- wdata  in  32  store data; right-justified for byte and half stores.
- rdata  out  32  load result, registered.
- rvalid  out  1  one-cycle strobe, qualifies rdata.
- misalign  out  1  one-cycle strobe: illegal or misaligned request.
- busy  out  1  clear sweep in progress; requests are ignored.

Behaviour:
- Reset (clr_n low, async):
  - rdata=0, rvalid=0, misalign=0, sweep pointer=0.
  - State=CLEAR if INIT_CLEAR, else READY.
  - busy=INIT_CLEAR.
- FSM states CLEAR and READY:
  - CLEAR: each cycle writes 0 to mem[ptr], then ptr++.
  - CLEAR: the cycle that writes ptr==DEPTH-1 moves to READY, so busy is high for exactly DEPTH cycles after clr_n rises.
  - READY is terminal until the next reset.
  - Reset mid-sweep restarts the sweep at word 0.
- Requests while busy: no write, rvalid=0, misalign=0.
- Alignment rules:
  - half needs address[0]=0.
  - word needs address[1:0]=0.
  - size=3 is always illegal.
- Illegal or misaligned request (sel and (ld or str)):
  - no memory write.
  - Next cycle: misalign=1, rvalid=0, rdata=0.
- Store (sel & str, aligned):
  - Word index = address[ADDR_W-1:2].
  - byte: lane address[1:0] <= wdata[7:0].
  - half: lanes {address[1],0} and {address[1],1} <= wdata[15:0].
  - word: all lanes <= wdata.
  - Write commits on the clock edge; other lanes are unchanged.
- Load (sel & ld, aligned):
  - Latency 1: next cycle rvalid=1 and rdata = selected byte/half/word, extended per uns.
  - Word loads ignore uns.
- Simultaneous ld & str, same request: read-before-write. rdata returns the pre-store contents and the store still commits.
- Back-to-back: a load in cycle N+1 of an address stored in cycle N returns the new data, since the write commits at the end of N.
- Non-load cycle (no sel, ld=0, busy, or misaligned): next cycle rdata=0 and rvalid=0, keeping the old "0 when not loading" contract for muxing.
- sel=0: no activity regardless of ld/str.
- Address bits at or above ADDR_W do not exist; there is no wrap logic beyond natural truncation.

Decomposition:
- Shared package data_ram_pkg:
  - size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2, SZ_RSV=2'd3.
  - FSM state encoding ST_CLEAR, ST_READY.
- One combinational sub-module, ram_lane_extract: inputs word, addr[1:0], size, uns; output extended 32-bit value.
- Lane-enable generation and the array stay in the top module.

Test Plan:
- Reset then sweep: pulse clr_n low with INIT_CLEAR=1 -> busy high exactly 1024 cycles. After busy falls, word load at 0x000 and at 0xFFC each returns 0x00000000 with rvalid=1.
- Byte store and signed load:
  - Store byte 0x80 at 0x102 -> word 0x40 reads 0x00800000.
  - Byte load at 0x102 with uns=0 -> 0xFFFFFF80; with uns=1 -> 0x00000080.
- Half store:
  - Word 0x12345678 at 0x200, then half 0xBEEF at 0x202 -> word reads 0xBEEF5678.
  - Half load at 0x200 with uns=0 -> 0x00005678.
- Misalignment:
  - Word store at 0x201 -> misalign=1 next cycle and memory unchanged.
  - Half load at 0x203 -> misalign=1, rvalid=0, rdata=0.
  - size=3 at 0x200 -> misalign=1.
- Simultaneous ld & str, word 0xAAAAAAAA at 0x300 holding 0x11111111:
  - rdata=0x11111111 next cycle.
  - A load the following cycle returns 0xAAAAAAAA.
- Reset mid-sweep and during access:
  - Assert clr_n low at sweep cycle 500 -> busy remains and the sweep restarts; total busy after release is 1024 cycles.
  - Assert clr_n low asynchronously while rvalid=1 -> rvalid, rdata and misalign go to 0 immediately.
